la_capture_buffer: RTL and testbench

Parametrised multi-channel logic-analyser capture block. Samples NUM_CH input channels into a DEPTH-entry circular buffer at a programmable rate. Supports a level or edge trigger with programmable pre-trigger depth, then streams the captured window out over a valid/ready port. Sits between the pad inputs (ui_in) and the readout/serialiser logic, as the next generation of the fixed 8-channel shift-register sampler.

---
 rtl/la_pkg.sv | 15 +
 rtl/la_capture_buffer_if.sv | 14 +
 rtl/la_sample_mem.sv | 23 ++
 rtl/la_capture_buffer.sv | 184 ++++++++++++++++++
 tb/tb_la_capture_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared types and widths for the logic-analyser capture block.
package la_pkg;

    localparam int STATE_W = 3;
    localparam int DIV_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_READ = 3'd4
    } la_state_e;

endpackage

// File: rtl/la_capture_buffer_if.sv
// Readout stream of the capture buffer.
// A word transfers on a clock edge where rd_valid && rd_ready; the producer holds
// rd_data/rd_last stable while rd_valid && !rd_ready, and never waits on rd_ready to raise rd_valid.
interface la_capture_buffer_if #(
    parameter int NUM_CH = 8
) ();
    logic [NUM_CH-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;

    modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
    modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/la_sample_mem.sv
// DEPTH x NUM_CH sample store: one synchronous write port, one combinational read port.
module la_sample_mem #(
    parameter int NUM_CH = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [NUM_CH-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [NUM_CH-1:0] rdata_o
);
    logic [NUM_CH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/la_capture_buffer.sv
// Multi-channel logic-analyser capture: prescaled sampling into a circular buffer,
// level/edge trigger with pre-trigger window, then valid/ready readout of the window.
module la_capture_buffer
    import la_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic [NUM_CH-1:0]  ch_in,
    input  logic               arm,
    input  logic               abort,
    input  logic [NUM_CH-1:0]  trig_mask,
    input  logic [NUM_CH-1:0]  trig_value,
    input  logic               trig_edge,
    input  logic [ADDR_W-1:0]  pre_count,
    input  logic [DIV_W-1:0]   div,
    output logic [STATE_W-1:0] state_o,
    output logic               trig_o,
    la_capture_buffer_if.master rd
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    la_state_e         state_q, state_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] value_q, value_d;
    logic              edge_q, edge_d;
    logic              prev_match_q, prev_match_d;
    logic              trig_q, trig_d;

    logic              tick;
    logic              capturing;
    logic              we;
    logic              match;
    logic              fire;
    logic              arm_go;
    logic              rd_valid_w;
    logic              rd_hs;
    logic [ADDR_W-1:0] post_init;
    logic [NUM_CH-1:0] mem_rdata;

    assign tick       = ena && (presc_q == div);
    assign capturing  = (state_q == ST_FILL) || (state_q == ST_WAIT) || (state_q == ST_POST);
    assign we         = tick && capturing && !abort;
    assign match      = ((ch_in ^ value_q) & mask_q) == '0;
    assign fire       = (state_q == ST_WAIT) && tick && !abort &&
                        (edge_q ? (match && !prev_match_q) : match);
    assign arm_go     = (state_q == ST_IDLE) && arm && !abort;
    assign rd_valid_w = (state_q == ST_READ);
    assign rd_hs      = rd_valid_w && rd.rd_ready;
    // Samples still to come after the trigger sample so the window totals DEPTH.
    assign post_init  = LAST - pre_q;

    la_sample_mem #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (ch_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            word_cnt_q   <= '0;
            pre_q        <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            edge_q       <= 1'b0;
            prev_match_q <= 1'b0;
            trig_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            word_cnt_q   <= word_cnt_d;
            pre_q        <= pre_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            edge_q       <= edge_d;
            prev_match_q <= prev_match_d;
            trig_q       <= trig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (arm) state_d = (pre_count != '0) ? ST_FILL : ST_WAIT;
                ST_FILL: if (tick && (ADDR_W'(fill_cnt_q + 1'b1) == pre_q)) state_d = ST_WAIT;
                ST_WAIT: if (fire) state_d = (post_init == '0) ? ST_READ : ST_POST;
                ST_POST: if (tick && (post_cnt_q == ADDR_W'(1))) state_d = ST_READ;
                ST_READ: if (rd_hs && (word_cnt_q == LAST)) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        presc_d      = presc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        word_cnt_d   = word_cnt_q;
        pre_d        = pre_q;
        mask_d       = mask_q;
        value_d      = value_q;
        edge_d       = edge_q;
        prev_match_d = prev_match_q;
        trig_d       = fire;

        // Wrap on >= so a div lowered mid-count cannot leave the prescaler stuck above it.
        if (ena) begin
            presc_d = (presc_q >= div) ? '0 : presc_q + 1'b1;
        end

        if (arm_go) begin
            presc_d      = '0;
            wr_ptr_d     = '0;
            fill_cnt_d   = '0;
            word_cnt_d   = '0;
            prev_match_d = 1'b0;
            pre_d        = pre_count;
            mask_d       = trig_mask;
            value_d      = trig_value;
            edge_d       = trig_edge;
        end

        if (we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if ((state_q == ST_FILL) && tick) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
        end
        if ((state_q == ST_WAIT) && tick) begin
            prev_match_d = match;
        end
        if (fire) begin
            post_cnt_d = post_init;
            rd_ptr_d   = wr_ptr_q - pre_q;
        end
        if ((state_q == ST_POST) && tick) begin
            post_cnt_d = post_cnt_q - 1'b1;
        end
        if (rd_hs) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_o     = state_q;
        trig_o      = trig_q;
        rd.rd_valid = rd_valid_w;
        rd.rd_last  = rd_valid_w && (word_cnt_q == LAST);
        rd.rd_data  = rd_valid_w ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_la_capture_buffer.sv
// Bench for la_capture_buffer: reference model works from the sample stream, not RTL state.
module tb_la_capture_buffer;
  localparam int NUM_CH = 8;
  localparam int DEPTH  = 16;

  logic       clk;
  logic       reset;
  logic       ena;
  logic [7:0] ch_in;
  logic       arm;
  logic       abort;
  logic [7:0] trig_mask;
  logic [7:0] trig_value;
  logic       trig_edge;
  logic [3:0] pre_count;
  logic [7:0] div;
  logic [2:0] state_o;
  logic       trig_o;

  int checks;
  int errors;

  la_capture_buffer_if #(.NUM_CH(NUM_CH)) rd_if ();

  la_capture_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .ch_in      (ch_in),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_edge  (trig_edge),
    .pre_count  (pre_count),
    .div        (div),
    .state_o    (state_o),
    .trig_o     (trig_o),
    .rd         (rd_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gen(input int mode, input int k);
    logic [6:0] r;
    r = 7'($urandom);
    case (mode)
      0:       gen = 8'h50 + 8'(k);
      2:       gen = {r, ((k < 2) || (k >= 5)) ? 1'b1 : 1'b0};
      default: gen = 8'($urandom);
    endcase
  endfunction

  // Drives one capture from arm to (partial) readout, checking state, trig_o and every word.
  task automatic run_capture(input string name, input int pre, input int dv,
                             input logic [7:0] mask, input logic [7:0] value, input bit edg,
                             input int gen_mode, input int ena_mode, input int rdy_mode,
                             input bit arm_in_read, input bit abort_post, input int read_words,
                             output int fire_idx);
    logic [7:0] samples[$];
    logic [7:0] exp_q[$];
    logic [7:0] s;
    int en_cnt, cyc, n, exp_st, hs;
    bit fired, prev, m, tick_now, fire_now, rdy, reached;
    samples.delete();
    exp_q.delete();
    fired = 0; prev = 0; en_cnt = 0; fire_idx = -1; hs = 0; reached = 0;

    pre_count = 4'(pre); div = 8'(dv); trig_mask = mask; trig_value = value;
    trig_edge = edg; ena = 1'b1; ch_in = 8'($urandom); arm = 1'b1;
    step();
    arm = 1'b0;
    checks++;
    if (state_o !== ((pre > 0) ? 3'd1 : 3'd2)) begin
      errors++;
      $display("FAIL %s arm_state: got %0d exp %0d", name, state_o, (pre > 0) ? 1 : 2);
    end

    for (cyc = 0; cyc < 4000; cyc++) begin
      case (ena_mode)
        0:       ena = 1'b1;
        1:       ena = ($urandom_range(0, 3) != 0);
        default: ena = !((cyc >= 2) && (cyc < 12));
      endcase
      tick_now = 0;
      if (ena) begin
        en_cnt++;
        tick_now = (en_cnt % (dv + 1)) == 0;
      end
      s = tick_now ? gen(gen_mode, samples.size()) : 8'($urandom);
      ch_in = s;
      trig_mask = 8'($urandom); trig_value = 8'($urandom);
      trig_edge = 1'($urandom); pre_count = 4'($urandom);
      fire_now = 0;
      if (tick_now) begin
        samples.push_back(s);
        if (!fired && (samples.size() > pre)) begin
          m = ((s ^ value) & mask) == 8'h00;
          fire_now = edg ? (m && !prev) : m;
          prev = m;
          if (fire_now) begin
            fired = 1;
            fire_idx = samples.size() - 1;
          end
        end
      end
      step();
      n = samples.size();
      if (!fired) exp_st = (n < pre) ? 1 : 2;
      else exp_st = (n < fire_idx + DEPTH - pre) ? 3 : 4;
      checks++;
      if (state_o !== 3'(exp_st)) begin
        errors++;
        $display("FAIL %s state: got %0d exp %0d (cycle %0d)", name, state_o, exp_st, cyc);
      end
      checks++;
      if (trig_o !== fire_now) begin
        errors++;
        $display("FAIL %s trig_o: got %0b exp %0b (cycle %0d)", name, trig_o, fire_now, cyc);
      end
      if (abort_post && (exp_st == 3)) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ((state_o !== 3'd0) || (rd_if.rd_valid !== 1'b0) || (trig_o !== 1'b0)) begin
          errors++;
          $display("FAIL %s abort: state %0d valid %0b trig %0b exp 0 0 0", name, state_o, rd_if.rd_valid, trig_o);
        end
        for (int i = 0; i < 6; i++) begin
          step();
          checks++;
          if ((state_o !== 3'd0) || (rd_if.rd_valid !== 1'b0)) begin
            errors++;
            $display("FAIL %s abort_hold: state %0d valid %0b exp 0 0", name, state_o, rd_if.rd_valid);
          end
        end
        return;
      end
      if (exp_st == 4) begin
        reached = 1;
        break;
      end
    end
    ena = 1'b1;
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL %s timeout: got state %0d exp 4", name, state_o);
      return;
    end

    for (int i = 0; i < DEPTH; i++) exp_q.push_back(samples[fire_idx - pre + i]);

    cyc = 0;
    while ((hs < read_words) && (cyc < 500)) begin
      checks++;
      if ((rd_if.rd_valid !== 1'b1) || (state_o !== 3'd4)) begin
        errors++;
        $display("FAIL %s rd_valid: got %0b state %0d exp 1 4", name, rd_if.rd_valid, state_o);
      end
      checks++;
      if (rd_if.rd_data !== exp_q[0]) begin
        errors++;
        $display("FAIL %s rd_data[%0d]: got %02h exp %02h", name, hs, rd_if.rd_data, exp_q[0]);
      end
      checks++;
      if (rd_if.rd_last !== (exp_q.size() == 1)) begin
        errors++;
        $display("FAIL %s rd_last[%0d]: got %0b exp %0b", name, hs, rd_if.rd_last, exp_q.size() == 1);
      end
      case (rdy_mode)
        0:       rdy = 1;
        1:       rdy = (cyc % 3) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (arm_in_read && (cyc == 1)) begin
        arm = 1'b1;
        rdy = 0;
      end
      rd_if.rd_ready = rdy;
      step();
      arm = 1'b0;
      if (rdy) begin
        void'(exp_q.pop_front());
        hs++;
      end
      cyc++;
    end
    rd_if.rd_ready = 1'b0;
    checks++;
    if (hs != read_words) begin
      errors++;
      $display("FAIL %s handshakes: got %0d exp %0d", name, hs, read_words);
    end
    if (read_words == DEPTH) begin
      checks++;
      if ((state_o !== 3'd0) || (rd_if.rd_valid !== 1'b0) || (rd_if.rd_data !== 8'h00) ||
          (rd_if.rd_last !== 1'b0)) begin
        errors++;
        $display("FAIL %s end: state %0d valid %0b data %02h last %0b exp 0 0 00 0", name,
                 state_o, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ena = 1'b1; ch_in = '0; arm = 1'b0; abort = 1'b0;
    trig_mask = '0; trig_value = '0; trig_edge = 1'b0; pre_count = '0; div = '0;
    rd_if.rd_ready = 1'b0;
    step(); step();
    checks++;
    if ((state_o !== 3'd0) || (trig_o !== 1'b0) || (rd_if.rd_valid !== 1'b0) ||
        (rd_if.rd_last !== 1'b0) || (rd_if.rd_data !== 8'h00)) begin
      errors++;
      $display("FAIL reset: state %0d trig %0b valid %0b last %0b data %02h exp all 0",
               state_o, trig_o, rd_if.rd_valid, rd_if.rd_last, rd_if.rd_data);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_level();
    int f;
    run_capture("level", 4, 0, 8'hFF, 8'h55, 0, 0, 0, 0, 0, 0, DEPTH, f);
    checks++;
    if (f != 5) begin
      errors++;
      $display("FAIL level fire_idx: got %0d exp 5", f);
    end
  endtask

  task automatic test_edge();
    int f;
    run_capture("edge", 3, 0, 8'h01, 8'h01, 1, 2, 0, 0, 0, 0, DEPTH, f);
    checks++;
    if (f != 5) begin
      errors++;
      $display("FAIL edge fire_idx: got %0d exp 5", f);
    end
  endtask

  task automatic test_backpressure();
    int f;
    run_capture("backpressure", 6, 0, 8'h03, 8'($urandom), 0, 1, 0, 1, 0, 0, DEPTH, f);
  endtask

  task automatic test_boundaries();
    int f;
    run_capture("pre0", 0, 0, 8'h0C, 8'($urandom), 0, 1, 0, 2, 0, 0, DEPTH, f);
    run_capture("pre15", 15, 0, 8'h30, 8'($urandom), 0, 1, 0, 2, 0, 0, DEPTH, f);
    run_capture("div3", 5, 3, 8'h81, 8'($urandom), 0, 1, 0, 0, 0, 0, DEPTH, f);
    run_capture("ena_gap", 8, 3, 8'h00, 8'h00, 0, 1, 2, 0, 0, 0, DEPTH, f);
    run_capture("ena_rand", 3, 1, 8'h42, 8'($urandom), 1, 1, 1, 2, 0, 0, DEPTH, f);
  endtask

  task automatic test_abort();
    int f;
    run_capture("abort_post", 2, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1, DEPTH, f);
    arm = 1'b1; abort = 1'b1; pre_count = 4'd3;
    step();
    arm = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((state_o !== 3'd0) || (rd_if.rd_valid !== 1'b0)) begin
        errors++;
        $display("FAIL arm_abort: state %0d valid %0b exp 0 0", state_o, rd_if.rd_valid);
      end
      step();
    end
    run_capture("arm_in_read", 7, 0, 8'h18, 8'($urandom), 0, 1, 0, 2, 1, 0, DEPTH, f);
  endtask

  task automatic test_reset_mid_read();
    int f;
    run_capture("pre_reset", 4, 0, 8'h06, 8'($urandom), 0, 1, 0, 0, 0, 0, 5, f);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ((state_o !== 3'd0) || (rd_if.rd_valid !== 1'b0) || (rd_if.rd_data !== 8'h00) ||
        (trig_o !== 1'b0)) begin
      errors++;
      $display("FAIL async_reset: state %0d valid %0b data %02h trig %0b exp 0 0 00 0",
               state_o, rd_if.rd_valid, rd_if.rd_data, trig_o);
    end
    #1;
    reset = 1'b0;
    step();
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_state: got %0d exp 0", state_o);
    end
    run_capture("after_reset", 9, 1, 8'h11, 8'($urandom), 0, 1, 0, 2, 0, 0, DEPTH, f);
  endtask

  task automatic test_random();
    int f, a, b;
    for (int t = 0; t < 6; t++) begin
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      run_capture("random", $urandom_range(0, 15), $urandom_range(0, 2),
                  8'((1 << a) | (1 << b)), 8'($urandom), 1'($urandom), 1,
                  $urandom_range(0, 1), 2, 0, 0, DEPTH, f);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_level();
    test_edge();
    test_backpressure();
    test_boundaries();
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
